// File: rtl/diffusion_mem_requester.sv
// rtl/diffusion_mem_requester.sv - per-lane requester agent for the banked score BRAM scheduler
module diffusion_mem_requester #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CONFLICT_LAT = 2,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_RETRY    = 15,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] lane_addr,
  output logic [DATA_WIDTH-1:0] lane_data,
  output logic                  lane_we,
  input  logic [DATA_WIDTH-1:0] lane_rdata,
  input  logic                  lane_conflict,
  output logic                  starve,
  output logic [15:0]           conflict_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(CONFLICT_LAT + 2);
  localparam int RW_W  = $clog2(MEM_LATENCY + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                    fifo_we_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [ADDR_WIDTH-1:0]   hold_addr_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;
  logic                    hold_we_q;
  logic [WC_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [RW_W-1:0]         rw_cnt_q, rw_cnt_d;
  logic [7:0]              retry_cnt_q, retry_cnt_d;
  logic [15:0]             conflict_cnt_q;
  logic                    starve_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q;
  logic                    wr_done_q, wr_done_d;
  logic                    push, pop, lost, done, fifo_empty, fifo_full;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready;

  // Lane is parked whenever no request is being issued or read back
  assign lane_addr    = (state_q == S_IDLE) ? PARK_ADDR : hold_addr_q;
  assign lane_data    = (state_q == S_IDLE) ? '0 : hold_data_q;
  assign lane_we      = (state_q == S_ISSUE) && hold_we_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_addr     = rsp_addr_q;
  assign wr_done      = wr_done_q;
  assign starve       = starve_q;
  assign conflict_cnt = conflict_cnt_q;

  // Next-state logic: arbitration sampling, retry and completion handling
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rw_cnt_d    = rw_cnt_q;
    retry_cnt_d = retry_cnt_q;
    rsp_valid_d = 1'b0;
    wr_done_d   = 1'b0;
    lost        = 1'b0;
    done        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_d     = S_ISSUE;
          wait_cnt_d  = '0;
          retry_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (wait_cnt_q == WC_W'(CONFLICT_LAT)) begin
          wait_cnt_d = '0;
          if (lane_conflict) begin
            lost = 1'b1;
            if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
          end else if (hold_we_q) begin
            wr_done_d = 1'b1;
            done      = 1'b1;
          end else begin
            state_d  = S_READ_WAIT;
            rw_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_READ_WAIT: begin
        if (rw_cnt_q == RW_W'(MEM_LATENCY - 1)) begin
          rsp_valid_d = 1'b1;
          done        = 1'b1;
        end else begin
          rw_cnt_d = rw_cnt_q + RW_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A finished request hands the lane straight to the next queued one
    if (done) begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        state_d     = S_ISSUE;
        wait_cnt_d  = '0;
        retry_cnt_d = '0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // FIFO storage carries no reset; only pointers and count are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_wdata;
      fifo_we_q[wr_ptr_q]   <= req_write;
    end
  end

  // Control state, FIFO pointers, hold registers and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      hold_we_q      <= 1'b0;
      wait_cnt_q     <= '0;
      rw_cnt_q       <= '0;
      retry_cnt_q    <= '0;
      conflict_cnt_q <= '0;
      starve_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_addr_q     <= '0;
      wr_done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rw_cnt_q    <= rw_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        hold_addr_q <= fifo_addr_q[rd_ptr_q];
        hold_data_q <= fifo_data_q[rd_ptr_q];
        hold_we_q   <= fifo_we_q[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (lost && conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
      if (lost && retry_cnt_d >= 8'(MAX_RETRY)) starve_q <= 1'b1;
      if (rsp_valid_d) begin
        rsp_rdata_q <= lane_rdata;
        rsp_addr_q  <= hold_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_diffusion_mem_requester.sv
// tb/tb_diffusion_mem_requester.sv - self-checking bench for diffusion_mem_requester
module tb_diffusion_mem_requester;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int CL = 2;
  localparam int ML = 1;
  localparam int MR = 15;
  localparam logic [AW-1:0] PARK = '1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_write = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          wr_done;
  logic [AW-1:0] lane_addr;
  logic [DW-1:0] lane_data;
  logic          lane_we;
  logic [DW-1:0] lane_rdata = '0;
  logic          lane_conflict = 1'b0;
  logic          starve;
  logic [15:0]   conflict_cnt;

  int   checks = 0;
  int   failures = 0;
  int   exp_conflicts = 0;
  req_t q[$];

  diffusion_mem_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CONFLICT_LAT(CL),
    .MEM_LATENCY(ML), .MAX_RETRY(MR), .PARK_ADDR(PARK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .wr_done(wr_done), .lane_addr(lane_addr), .lane_data(lane_data),
    .lane_we(lane_we), .lane_rdata(lane_rdata), .lane_conflict(lane_conflict),
    .starve(starve), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    req_t t;
    int   guard;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL push_timeout got_ready=%b exp=1", req_ready);
    end else begin
      t.addr = a; t.data = d; t.we = w;
      q.push_back(t);
    end
    step();
    req_valid = 1'b0;
  endtask

  // Plays the scheduler for the request at the head of the model queue:
  // it loses n arbitration samples (one every CL+1 lane cycles), then wins.
  task automatic run_txn(input int n, input logic [DW-1:0] rd_val);
    req_t t;
    int   guard;
    guard = 0;
    while (!(q.size() > 0 && lane_addr !== PARK) && guard < 100) begin
      checks++;
      if (lane_we !== 1'b0) begin
        failures++;
        $display("FAIL idle_we got=%b exp=0", lane_we);
      end
      lane_conflict = 1'($urandom);
      step();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("FAIL lane_start_timeout got_addr=%h qsize=%0d", lane_addr, q.size());
      return;
    end
    t = q.pop_front();
    for (int k = 0; k < (n + 1) * (CL + 1); k++) begin
      checks++;
      if (lane_addr !== t.addr || lane_we !== t.we || (t.we && lane_data !== t.data)) begin
        failures++;
        $display("FAIL issue_lane k=%0d got=%h/%b/%h exp=%h/%b/%h", k, lane_addr, lane_we,
                 lane_data, t.addr, t.we, t.data);
      end
      if (k > 0) begin
        checks++;
        if (rsp_valid !== 1'b0 || wr_done !== 1'b0) begin
          failures++;
          $display("FAIL early_pulse k=%0d got=%b/%b exp=0/0", k, rsp_valid, wr_done);
        end
      end
      if (k % (CL + 1) == CL) lane_conflict = ((k / (CL + 1)) < n);
      else                    lane_conflict = 1'($urandom);
      lane_rdata = $urandom;
      step();
    end
    exp_conflicts += n;
    if (!t.we) begin
      for (int j = 0; j < ML; j++) begin
        checks++;
        if (lane_addr !== t.addr || lane_we !== 1'b0) begin
          failures++;
          $display("FAIL read_wait_lane got=%h/%b exp=%h/0", lane_addr, lane_we, t.addr);
        end
        lane_conflict = 1'($urandom);
        lane_rdata = (j == ML - 1) ? rd_val : $urandom;
        step();
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_addr !== t.addr || rsp_rdata !== rd_val || wr_done !== 1'b0) begin
        failures++;
        $display("FAIL read_rsp got=%b/%h/%h/%b exp=1/%h/%h/0", rsp_valid, rsp_addr, rsp_rdata,
                 wr_done, t.addr, rd_val);
      end
    end else begin
      checks++;
      if (wr_done !== 1'b1 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL write_done got=%b/%b exp=1/0", wr_done, rsp_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (req_ready !== 1'b1 || lane_addr !== PARK || lane_we !== 1'b0 || lane_data !== '0 ||
        rsp_valid !== 1'b0 || wr_done !== 1'b0 || starve !== 1'b0 || conflict_cnt !== 16'd0 ||
        rsp_rdata !== '0 || rsp_addr !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b/%h/%b/%h/%b/%b/%b/%h exp=1/%h/0/0/0/0/0/0", req_ready,
               lane_addr, lane_we, lane_data, rsp_valid, wr_done, starve, conflict_cnt, PARK);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_park();
    for (int i = 0; i < 8; i++) begin
      lane_conflict = 1'($urandom);
      checks++;
      if (lane_addr !== PARK || lane_we !== 1'b0 || rsp_valid !== 1'b0 || wr_done !== 1'b0) begin
        failures++;
        $display("FAIL idle_park got=%h/%b/%b/%b exp=%h/0/0/0", lane_addr, lane_we, rsp_valid,
                 wr_done, PARK);
      end
      step();
    end
    lane_conflict = 1'b0;
  endtask

  task automatic test_read_no_conflict();
    push_req(13'd5, 32'h0, 1'b0);
    run_txn(0, 32'hDEADBEEF);
    step();
    checks++;
    if (lane_addr !== PARK || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_after got=%h/%b exp=%h/0", lane_addr, rsp_valid, PARK);
    end
  endtask

  task automatic test_write_conflicts();
    push_req(13'd3, 32'h11, 1'b1);
    run_txn(2, 32'h0);
    checks++;
    if (conflict_cnt !== 16'(exp_conflicts)) begin
      failures++;
      $display("FAIL write_conflict_cnt got=%0d exp=%0d", conflict_cnt, exp_conflicts);
    end
    step();
    checks++;
    if (lane_we !== 1'b0 || lane_addr !== PARK || wr_done !== 1'b0) begin
      failures++;
      $display("FAIL write_after got=%b/%h/%b exp=0/%h/0", lane_we, lane_addr, wr_done, PARK);
    end
  endtask

  task automatic test_fifo_full();
    fork
      begin
        push_req(13'd100, 32'hA5A5_0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
          req_t t;
          t.addr = 13'(200 + i); t.data = $urandom; t.we = 1'($urandom);
          req_valid = 1'b1; req_addr = t.addr; req_wdata = t.data; req_write = t.we;
          checks++;
          if (req_ready !== (i < FD)) begin
            failures++;
            $display("FAIL fifo_ready i=%0d got=%b exp=%b", i, req_ready, (i < FD));
          end
          if (i < FD) q.push_back(t);
          step();
        end
        req_valid = 1'b0;
      end
      run_txn(3, 32'h0);
    join
    for (int i = 0; i < FD; i++) run_txn($urandom_range(0, 1), $urandom);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL fifo_drain got=%0d exp=0", q.size());
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || wr_done !== 1'b0 || lane_addr !== PARK) begin
        failures++;
        $display("FAIL fifo_dropped got=%b/%b/%h exp=0/0/%h", rsp_valid, wr_done, lane_addr, PARK);
      end
    end
  endtask

  task automatic test_starve();
    for (int r = 0; r < 2; r++) begin
      push_req(13'd7, 32'h0, 1'b0);
      run_txn(MR - 1, $urandom);
      checks++;
      if (starve !== 1'b0) begin
        failures++;
        $display("FAIL starve_early r=%0d got=%b exp=0", r, starve);
      end
    end
    push_req(13'd8, 32'h0, 1'b0);
    run_txn(MR + 1, $urandom);
    checks++;
    if (starve !== 1'b1) begin
      failures++;
      $display("FAIL starve_set got=%b exp=1", starve);
    end
    push_req(13'd9, 32'h1234, 1'b1);
    run_txn(0, 32'h0);
    checks++;
    if (starve !== 1'b1 || conflict_cnt !== 16'(exp_conflicts)) begin
      failures++;
      $display("FAIL starve_sticky got=%b/%0d exp=1/%0d", starve, conflict_cnt, exp_conflicts);
    end
  endtask

  task automatic test_random();
    int done_cnt;
    done_cnt = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) step();
          push_req(13'($urandom_range(0, 8190)), $urandom, 1'($urandom));
        end
      end
      begin
        while (done_cnt < 20) begin
          run_txn($urandom_range(0, 2), $urandom);
          done_cnt++;
        end
      end
    join
    step();
    checks++;
    if (conflict_cnt !== 16'(exp_conflicts)) begin
      failures++;
      $display("FAIL random_conflict_cnt got=%0d exp=%0d", conflict_cnt, exp_conflicts);
    end
  endtask

  task automatic test_reset_mid_read();
    int guard;
    push_req(13'd9, 32'h0, 1'b0);
    guard = 0;
    while (lane_addr !== 13'd9 && guard < 20) begin
      step();
      guard++;
    end
    q.delete();
    for (int k = 0; k < CL + 1; k++) begin
      lane_conflict = 1'b0;
      step();
    end
    checks++;
    if (lane_addr !== 13'd9) begin
      failures++;
      $display("FAIL midread_lane got=%h exp=009", lane_addr);
    end
    lane_rdata = 32'hCAFE_F00D;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_conflicts = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lane_addr !== PARK || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
          conflict_cnt !== 16'd0 || starve !== 1'b0 || wr_done !== 1'b0) begin
        failures++;
        $display("FAIL midread_reset i=%0d got=%h/%b/%b/%0d/%b/%b exp=%h/0/1/0/0/0", i,
                 lane_addr, rsp_valid, req_ready, conflict_cnt, starve, wr_done, PARK);
      end
      step();
    end
  endtask

  initial begin
    step();
    test_reset();
    test_idle_park();
    test_read_no_conflict();
    test_write_conflicts();
    test_fifo_full();
    test_starve();
    test_random();
    test_reset_mid_read();
    test_idle_park();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
